// File: rtl/seg_display_scanner.sv
// Time-multiplexed driver for a four-digit common-anode 7-segment display.
// Inputs are captured into shadow registers once per frame so a digit never shows a half-updated value.
module seg_display_scanner #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [15:0]      sh_val_q, sh_val_d;
  logic [3:0]       sh_dp_q, sh_dp_d;
  logic             sh_blank_q, sh_blank_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             fd_q, fd_d;
  logic             wrap, load;
  logic [3:0]       nib;

  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    wrap    = (cnt_q == LAST);
    cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
    digit_d = wrap ? digit_q + 2'd1 : digit_q;
    // Reset parks the scan at the last cycle of digit 3, so the first edge is a frame load.
    load    = wrap && (digit_q == 2'd3);

    sh_val_d   = load ? value : sh_val_q;
    sh_dp_d    = load ? dp_in : sh_dp_q;
    sh_blank_d = load ? blank : sh_blank_q;
    fd_d       = load;

    // Outputs are derived from post-edge digit and shadow state so they line up with the scan.
    nib = 4'(sh_val_d >> {digit_d, 2'b00});
    if (sh_blank_d) begin
      an_d  = 4'hF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(4'b0001 << digit_d);
      seg_d = hex2seg(nib);
      dp_d  = ~sh_dp_d[digit_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= LAST;
      digit_q    <= 2'd3;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= 1'b0;
      an_q       <= 4'hF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      sh_val_q   <= sh_val_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fd_q       <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign frame_done = fd_q;

endmodule
